// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//   Shared AES definitions for the encrypt datapath:
//     byte_t      - one state byte
//     STATE_W     - width of a full 128-bit AES state
//     STATE_BYTES - number of bytes in a state
//     fsm_state_e - control states of the iterative SubBytes engine
//     SBOX        - forward S-box table (index = input byte)
//     sbox_fwd()  - forward S-box lookup helper
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam int STATE_W     = 128;
    localparam int STATE_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    // Entry 0 is the first element of the concatenation because the outer
    // dimension is declared ascending.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic byte_t sbox_fwd(input byte_t b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/sub_bytes_iter_s_box.sv
// -----------------------------------------------------------------------------
// s_box
//   Purely combinational forward AES S-box for one byte.
//   Ports:
//     byte_i  in  8  byte to substitute
//     byte_o  out 8  SBOX(byte_i)
// -----------------------------------------------------------------------------
module s_box
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    // Table lookup of the forward substitution
    always_comb begin
        byte_o = sbox_fwd(byte_i);
    end

endmodule

// File: rtl/sub_bytes_iter.sv
// -----------------------------------------------------------------------------
// sub_bytes_iter
//   Iterative AES SubBytes engine. A 128-bit state is captured on an input
//   handshake, then LANES bytes are substituted per clock (NG = 16/LANES
//   groups), and the result is held on the output until the consumer takes it.
//   Parameters:
//     LANES      S-box instances / bytes per cycle; 1, 2, 4, 8 or 16
//   Ports:
//     clk        in   1    rising-edge clock
//     rst        in   1    asynchronous active-high reset
//     in_valid   in   1    in_state is valid
//     in_ready   out  1    engine is idle and can capture a state
//     in_state   in   128  byte 0 = [127:120] ... byte 15 = [7:0]
//     out_valid  out  1    out_state holds a complete result
//     out_ready  in   1    consumer takes out_state
//     out_state  out  128  substituted state, same byte order
//     busy       out  1    engine is in RUN or DONE
// -----------------------------------------------------------------------------
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 4
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NG    = STATE_BYTES / LANES;
    localparam int GRP_W = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NG - 1);

    fsm_state_e           state_q, state_d;
    logic [GRP_W-1:0]     grp_q, grp_d;
    logic [STATE_W-1:0]   work_q, work_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    byte_t lane_in_s  [LANES];
    byte_t lane_out_s [LANES];

    // Select the bytes of the current group from the working copy; byte n
    // lives at bits [127-8n -: 8].
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_in_s[k] = work_q[STATE_W - 1 - 8 * (int'(grp_q) * LANES + k) -: 8];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        s_box u_s_box (
            .byte_i (lane_in_s[k]),
            .byte_o (lane_out_s[k])
        );
    end

    // Next-state, group counter and working-register update
    always_comb begin
        state_d     = state_q;
        grp_d       = grp_q;
        work_d      = work_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    grp_d   = {GRP_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int k = 0; k < LANES; k++) begin
                    work_d[STATE_W - 1 - 8 * (int'(grp_q) * LANES + k) -: 8] = lane_out_s[k];
                end
                if (grp_q == GRP_LAST) begin
                    // Counter wraps only here, so it never exceeds NG-1
                    state_d     = DONE;
                    grp_d       = {GRP_W{1'b0}};
                    out_valid_d = 1'b1;
                end else begin
                    grp_d = grp_q + GRP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                grp_d       = {GRP_W{1'b0}};
                out_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, counter, working copy and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grp_q       <= {GRP_W{1'b0}};
            work_q      <= {STATE_W{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            work_q      <= work_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // in_ready depends only on state and rst, never on in_valid, so the
    // upstream handshake cannot form a combinational loop through here.
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = out_valid_q;
        busy      = busy_q;
        out_state = work_q;
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// -----------------------------------------------------------------------------
// tb_sub_bytes_iter
//   Self-checking bench for sub_bytes_iter. The main instance (LANES=4) is
//   driven through directed and random jobs; every accepted state pushes its
//   expected result (from a GF(2^8)-derived S-box model) into a scoreboard,
//   and an independent monitor pops and compares on each output handshake.
//   Two extra instances (LANES=1, LANES=16) check latency and the reference
//   vector at the other parameter extremes.
// -----------------------------------------------------------------------------
module tb_sub_bytes_iter;

    localparam int NG = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, out_ready;
    logic [127:0] in_state;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_state;

    logic         v1, r1, v16, r16;
    logic         ir1, ov1, b1, ir16, ov16, b16;
    logic [127:0] os1, os16;

    sub_bytes_iter #(.LANES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .busy(busy));

    sub_bytes_iter #(.LANES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1),
        .in_state(in_state), .out_valid(ov1), .out_ready(r1),
        .out_state(os1), .busy(b1));

    sub_bytes_iter #(.LANES(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir16),
        .in_state(in_state), .out_valid(ov16), .out_ready(r16),
        .out_state(os16), .busy(b16));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    logic ov_prev = 1'b0;

    typedef struct {
        logic [127:0] inp;
        logic [127:0] exp;
        int           acc;
    } job_t;
    job_t sbq[$];
    job_t mj;

    logic [7:0] ref_sbox [256];
    logic [7:0] ref_inv  [256];

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        logic       hi;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box = affine transform of the multiplicative inverse in GF(2^8)
    function automatic void build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            ref_sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) ref_inv[ref_sbox[x]] = 8'(x);
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = ref_sbox[s[127 - 8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] ref_unsub(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = ref_inv[s[127 - 8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- scoreboard tap and monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && !ov_prev) begin
                    if (sbq.size() == 0) timeout("unexpected_out_valid");
                    else check("latency", 128'(cyc - sbq[0].acc), 128'(NG));
                end
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        timeout("unexpected_output");
                    end else begin
                        mj = sbq.pop_front();
                        check("out_state", out_state, mj.exp);
                        check("inverse_recovers_input", ref_unsub(out_state), mj.inp);
                    end
                end
                // Handshake will complete on the next rising edge
                if (in_valid && in_ready) begin
                    sbq.push_back('{in_state, ref_sub(in_state), cyc + 1});
                    acc_cnt++;
                end
            end
            ov_prev = out_valid;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send(input logic [127:0] s);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_state = s;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_state = rand128();
        if (!ok) timeout("send_accept");
    endtask

    task automatic expect_out(input string name, input logic [127:0] exp);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (out_valid) begin got = 1'b1; break; end
        end
        if (!got) timeout(name);
        else check(name, out_state, exp);
    endtask

    task automatic run_alt(input int sel, input logic [127:0] s, input logic [127:0] exp, input int ng);
        int  c0;
        bit  got;
        got = 1'b0;
        @(posedge clk); #1;
        in_state = s;
        if (sel == 0) v1 = 1'b1; else v16 = 1'b1;
        @(negedge clk);
        check("alt_in_ready", (sel == 0) ? ir1 : ir16, 128'd1);
        c0 = cyc + 1;
        @(posedge clk); #1;
        v1 = 1'b0; v16 = 1'b0;
        in_state = rand128();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((sel == 0) ? ov1 : ov16) begin got = 1'b1; break; end
        end
        if (!got) begin
            timeout("alt_out_valid");
        end else begin
            check("alt_latency", 128'(cyc - c0), 128'(ng));
            check("alt_out_state", (sel == 0) ? os1 : os16, exp);
            check("alt_busy", (sel == 0) ? b1 : b16, 128'd1);
        end
        @(posedge clk); #1;
        if (sel == 0) r1 = 1'b1; else r16 = 1'b1;
        @(posedge clk); #1;
        r1 = 1'b0; r16 = 1'b0;
        @(negedge clk);
        check("alt_released", {(sel == 0) ? ov1 : ov16, (sel == 0) ? ir1 : ir16}, 128'b01);
    endtask

    // ---------------- main sequence ----------------
    localparam logic [127:0] VEC_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] VEC_OUT = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816;

    bit rand_done;
    int acc0;

    initial begin
        build_tables();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = 128'h0;
        v1 = 1'b0; r1 = 1'b0; v16 = 1'b0; r16 = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 128'd0);
        check("reset_out_valid", out_valid, 128'd0);
        check("reset_busy", busy, 128'd0);
        check("reset_out_state", out_state, 128'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 128'd1);

        // All-zero state
        out_ready = 1'b1;
        send(128'h0);
        expect_out("zero_state", {16{8'h63}});

        // Reference vector on all three lane counts
        send(VEC_IN);
        expect_out("vector_lanes4", VEC_OUT);
        run_alt(0, VEC_IN, VEC_OUT, 16);
        run_alt(1, VEC_IN, VEC_OUT, 1);

        // Backpressure: result must hold while the consumer stalls
        @(posedge clk); #1 out_ready = 1'b0;
        send(VEC_IN ^ 128'h0f0f);
        expect_out("bp_first", ref_sub(VEC_IN ^ 128'h0f0f));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", {out_valid, in_ready, busy, out_state},
                  {1'b1, 1'b0, 1'b1, ref_sub(VEC_IN ^ 128'h0f0f)});
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_release", {out_valid, in_ready, busy}, 128'b010);

        // Continuous in_valid with a new state every cycle: one capture per job
        out_ready = 1'b1;
        acc0 = acc_cnt;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_state = rand128();
        end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        check("stream_accept_count", 128'(acc_cnt - acc0), 128'd10);

        // Reset in the middle of RUN, after two groups are done
        send(rand128());
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        sbq.delete();
        #1;
        check("midrun_rst", {out_valid, busy, in_ready}, 128'b000);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {in_ready, busy}, 128'b10);
        send({128{1'b1}});
        expect_out("all_ones", {16{8'h16}});

        // Random jobs with random input gaps and random consumer stalls
        rand_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send(rand128());
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clk); #1 out_ready = 1'b1;
        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 128'(sbq.size()), 128'd0);
        check("random_accept_count", 128'(acc_cnt - acc0), 128'd1012);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
